// File: rtl/pixel_pair_pack.sv
// pixel_pair_pack: packs a one-pixel-per-beat RGB stream into two-pixel FIFO
// words {odd_pixel, even_pixel}, tracking frame coordinates and flagging
// start-of-frame / end-of-line on each word.
// Optional feature macro: PIXEL_PAIR_PACK_RESYNC_EN. When defined, a transfer
// with in_sof=1 realigns the packer to x=0,y=0 and counts misalignments in
// err_cnt. When undefined, in_sof is ignored and err_cnt reads 0.
module pixel_pair_pack #(
  parameter int H  = 1920,
  parameter int V  = 1080,
  parameter int RD = 5,
  parameter int GD = 6,
  parameter int BD = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [RD+GD+BD-1:0]           in_pix,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_sof,
  input  logic                          fifo_full,
  output logic [2*(RD+GD+BD)-1:0]       out_data,
  output logic                          out_wr,
  output logic [$clog2(H)-1:0]          out_x,
  output logic [$clog2(V)-1:0]          out_y,
  output logic                          out_sof,
  output logic                          out_eol,
  output logic [7:0]                    err_cnt
);

  localparam int W  = RD + GD + BD;
  localparam int XW = $clog2(H);
  localparam int YW = $clog2(V);
  localparam logic [XW-1:0] XLAST = XW'(H - 2);
  localparam logic [YW-1:0] YLAST = YW'(V - 1);

  typedef enum logic {EVEN = 1'b0, ODD = 1'b1} state_t;

  state_t          state_q;
  logic [W-1:0]    hold_q;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [2*W-1:0]  out_data_q;
  logic [XW-1:0]   out_x_q;
  logic [YW-1:0]   out_y_q;
  logic            out_wr_q, out_sof_q, out_eol_q;
  logic            xfer;
  logic            resync;

  // The only stall point is completing a pair while the FIFO is full.
  assign in_ready = (state_q == EVEN) | ~fifo_full;
  assign xfer     = in_valid & in_ready;

`ifdef PIXEL_PAIR_PACK_RESYNC_EN
  logic [7:0] err_q;

  assign resync = xfer & in_sof;

  // Count realignments that throw away a held pixel or land mid-frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 8'd0;
    end else if (resync && (state_q == ODD || x_q != '0 || y_q != '0) &&
                 err_q != 8'hFF) begin
      err_q <= err_q + 8'd1;
    end
  end

  assign err_cnt = err_q;
`else
  logic unused_sof;

  assign resync     = 1'b0;
  assign unused_sof = in_sof;
  assign err_cnt    = 8'd0;
`endif

  // Coordinates of the word after the one being written (raster wrap).
  always_comb begin
    x_d = x_q + XW'(2);
    y_d = y_q;
    if (x_q == XLAST) begin
      x_d = '0;
      y_d = (y_q == YLAST) ? '0 : y_q + YW'(1);
    end
  end

  // Pairing FSM with registered word outputs; out_wr is a one-cycle strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= EVEN;
      hold_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      out_data_q <= '0;
      out_x_q    <= '0;
      out_y_q    <= '0;
      out_wr_q   <= 1'b0;
      out_sof_q  <= 1'b0;
      out_eol_q  <= 1'b0;
    end else begin
      out_wr_q <= 1'b0;
      if (resync) begin
        // A start-of-frame pixel always becomes the even pixel of (0,0).
        hold_q  <= in_pix;
        x_q     <= '0;
        y_q     <= '0;
        state_q <= ODD;
      end else if (xfer) begin
        case (state_q)
          EVEN: begin
            hold_q  <= in_pix;
            state_q <= ODD;
          end
          ODD: begin
            out_data_q <= {in_pix, hold_q};
            out_x_q    <= x_q;
            out_y_q    <= y_q;
            out_sof_q  <= (x_q == '0) && (y_q == '0);
            out_eol_q  <= (x_q == XLAST);
            out_wr_q   <= 1'b1;
            x_q        <= x_d;
            y_q        <= y_d;
            state_q    <= EVEN;
          end
          default: state_q <= EVEN;
        endcase
      end
    end
  end

  assign out_data = out_data_q;
  assign out_x    = out_x_q;
  assign out_y    = out_y_q;
  assign out_wr   = out_wr_q;
  assign out_sof  = out_sof_q;
  assign out_eol  = out_eol_q;

endmodule
